// File: rtl/m1_uart_rx_fifo.sv
// m1_uart_rx_fifo
// Fabric-side 8N1 UART receiver for the Cortex-M1 UART1TXD line.
// The line is sampled 16x per bit. Each bit is read at its centre, and a short
// low glitch is rejected as a false start. Received bytes go into a
// first-word-fall-through FIFO that drives a valid/ready stream. Two sticky
// flags report a low stop bit (frame_err) and a byte dropped because the FIFO
// was full (overflow).

module m1_uart_rx_fifo #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          HCLK,
  input  logic                          hwRst,
  input  logic                          rxd,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          clr_err
);

  // Clocks per oversampling tick, rounded to nearest.
  localparam int DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  localparam logic [PW-1:0] DIV_LAST   = PW'(DIV - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  // Parameter sanity: refuse to elaborate an unusable divider or FIFO size.
  if (DIV < 1) begin : gBadDiv
    $error("m1_uart_rx_fifo: CLK_HZ too low for BAUD (DIV < 1)");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
    $error("m1_uart_rx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  logic          sync1_q;
  logic          rxdS_q;
  logic [PW-1:0] presc_q;
  logic          tick;
  logic          startDet;

  state_t        state_q;
  logic [3:0]    scnt_q;
  logic [2:0]    bcnt_q;
  logic [7:0]    shreg_q;
  logic          pushReq_q;
  logic          frameErr_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    rxData_q, rxData_d;
  logic          valid_q, valid_d;
  logic          overflow_q;

  logic          pop;
  logic          full;
  logic          wrEn;
  logic          ovfSet;
  logic          headFromPush;

  // Two-flop synchronizer. It resets to the idle-high line level so that
  // reset never produces a false start.
  always_ff @(posedge HCLK or posedge hwRst) begin
    if (hwRst) begin
      sync1_q <= 1'b1;
      rxdS_q  <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxdS_q  <= sync1_q;
    end
  end

  assign tick     = (presc_q == DIV_LAST);
  assign startDet = (state_q == ST_IDLE) && !rxdS_q;

  // Oversampling prescaler. It free-runs and realigns to the start edge so
  // that tick phase is fixed relative to the frame.
  always_ff @(posedge HCLK or posedge hwRst) begin
    if (hwRst) begin
      presc_q <= '0;
    end else if (startDet || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Receive FSM. It finds the start bit, samples each bit at its centre and
  // requests a FIFO push on a good stop bit. A low stop bit flags a framing
  // error and waits out the break.
  always_ff @(posedge HCLK or posedge hwRst) begin
    if (hwRst) begin
      state_q    <= ST_IDLE;
      scnt_q     <= '0;
      bcnt_q     <= '0;
      shreg_q    <= '0;
      pushReq_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      pushReq_q <= 1'b0;
      if (clr_err) begin
        frameErr_q <= 1'b0;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (!rxdS_q) begin
            state_q <= ST_START;
            scnt_q  <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (scnt_q == 4'd7) begin
              if (!rxdS_q) begin
                state_q <= ST_DATA;
                scnt_q  <= '0;
                bcnt_q  <= '0;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              scnt_q <= scnt_q + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            scnt_q <= scnt_q + 4'd1;
            if (scnt_q == 4'd15) begin
              shreg_q <= {rxdS_q, shreg_q[7:1]};
              if (bcnt_q == 3'd7) begin
                state_q <= ST_STOP;
              end else begin
                bcnt_q <= bcnt_q + 3'd1;
              end
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            scnt_q <= scnt_q + 4'd1;
            if (scnt_q == 4'd15) begin
              if (rxdS_q) begin
                pushReq_q <= 1'b1;
                state_q   <= ST_IDLE;
              end else begin
                frameErr_q <= 1'b1;
                state_q    <= ST_BREAK;
              end
            end
          end
        end
        ST_BREAK: begin
          if (rxdS_q) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // A push into a full FIFO is accepted only when the head leaves in the
  // same cycle. Otherwise the byte is dropped and overflow is flagged.
  assign pop    = valid_q & rx_ready;
  assign full   = (count_q == COUNT_FULL);
  assign wrEn   = pushReq_q & (~full | pop);
  assign ovfSet = pushReq_q & full & ~pop;

  // The new byte becomes the head directly when the FIFO is, or is about to
  // be, empty.
  assign headFromPush = wrEn && ((count_q == '0) || ((count_q == CW'(1)) && pop));

  // Next-state for pointers, occupancy and the registered head byte. The
  // head keeps its last value once the FIFO drains.
  always_comb begin
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    count_d  = count_q;
    rxData_d = rxData_q;
    if (wrEn) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    if (wrEn && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!wrEn && pop) begin
      count_d = count_q - 1'b1;
    end
    if (headFromPush) begin
      rxData_d = shreg_q;
    end else if (count_d != '0) begin
      rxData_d = mem_q[rdPtr_d];
    end
    valid_d = (count_d != '0);
  end

  // FIFO storage. It needs no reset because the head is presented from its
  // own register.
  always_ff @(posedge HCLK) begin
    if (wrEn) begin
      mem_q[wrPtr_q] <= shreg_q;
    end
  end

  // FIFO control registers and the registered stream outputs.
  always_ff @(posedge HCLK or posedge hwRst) begin
    if (hwRst) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      rxData_q <= 8'h00;
      valid_q  <= 1'b0;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
      rxData_q <= rxData_d;
      valid_q  <= valid_d;
    end
  end

  // Sticky overflow flag. A new overflow beats a simultaneous clear.
  always_ff @(posedge HCLK or posedge hwRst) begin
    if (hwRst) begin
      overflow_q <= 1'b0;
    end else if (ovfSet) begin
      overflow_q <= 1'b1;
    end else if (clr_err) begin
      overflow_q <= 1'b0;
    end
  end

  assign rx_data    = rxData_q;
  assign rx_valid   = valid_q;
  assign fifo_count = count_q;
  assign frame_err  = frameErr_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_m1_uart_rx_fifo.sv
// tb_m1_uart_rx_fifo
// Directed bench for m1_uart_rx_fifo with DIV=1 (16 HCLK per bit) and a
// four-entry FIFO. Frames are driven with # delays so that off-nominal baud
// rates can be applied.

`timescale 1ns/1ps

module tb_m1_uart_rx_fifo;

  localparam int BIT_NS = 160;

  logic       HCLK;
  logic       hwRst;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [2:0] fifo_count;
  logic       frame_err;
  logic       overflow;
  logic       clr_err;

  int checks   = 0;
  int failures = 0;

  m1_uart_rx_fifo #(
    .CLK_HZ     (1_843_200),
    .BAUD       (115200),
    .FIFO_DEPTH (4)
  ) dut (
    .HCLK       (HCLK),
    .hwRst      (hwRst),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .clr_err    (clr_err)
  );

  // 100 MHz bench clock; posedges fall on 5 ns + 10k.
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one 8N1 frame with the chosen bit period. The frame starts 2 ns
  // after a rising edge so that line changes never coincide with a clock edge.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                               input int bitNs);
    @(posedge HCLK);
    #2;
    rxd = 1'b0;
    #(bitNs);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      #(bitNs);
    end
    rxd = stopBit;
    #(bitNs);
  endtask

  // Hold rx_ready for exactly one rising edge.
  task automatic popOne;
    @(negedge HCLK);
    rx_ready = 1'b1;
    @(negedge HCLK);
    rx_ready = 1'b0;
  endtask

  // Pulse clr_err for one rising edge.
  task automatic clearErrors;
    @(negedge HCLK);
    clr_err = 1'b1;
    @(negedge HCLK);
    clr_err = 1'b0;
  endtask

  task automatic settle;
    repeat (4) @(negedge HCLK);
  endtask

  initial begin
    hwRst    = 1'b1;
    rxd      = 1'b1;
    rx_ready = 1'b0;
    clr_err  = 1'b0;
    repeat (3) @(negedge HCLK);
    checkOutput("rstValid", 32'(rx_valid), 32'd0);
    checkOutput("rstData", 32'(rx_data), 32'h00);
    checkOutput("rstCount", 32'(fifo_count), 32'd0);
    checkOutput("rstFrameErr", 32'(frame_err), 32'd0);
    checkOutput("rstOverflow", 32'(overflow), 32'd0);
    hwRst = 1'b0;
    repeat (3) @(negedge HCLK);

    // Single byte, not consumed.
    applyStimulus(8'hA5, 1'b1, BIT_NS);
    settle();
    checkOutput("a5Valid", 32'(rx_valid), 32'd1);
    checkOutput("a5Data", 32'(rx_data), 32'hA5);
    checkOutput("a5Count", 32'(fifo_count), 32'd1);
    checkOutput("a5FrameErr", 32'(frame_err), 32'd0);
    checkOutput("a5Overflow", 32'(overflow), 32'd0);
    popOne();
    checkOutput("a5PopCount", 32'(fifo_count), 32'd0);
    checkOutput("a5PopValid", 32'(rx_valid), 32'd0);
    checkOutput("a5HoldData", 32'(rx_data), 32'hA5);

    // rx_ready while empty must not underflow.
    @(negedge HCLK);
    rx_ready = 1'b1;
    repeat (3) @(negedge HCLK);
    rx_ready = 1'b0;
    checkOutput("emptyPopCount", 32'(fifo_count), 32'd0);
    checkOutput("emptyPopValid", 32'(rx_valid), 32'd0);

    // Short low glitch is rejected without a flag.
    @(negedge HCLK);
    rxd = 1'b0;
    repeat (5) @(negedge HCLK);
    rxd = 1'b1;
    repeat (40) @(negedge HCLK);
    checkOutput("glitchCount", 32'(fifo_count), 32'd0);
    checkOutput("glitchFrameErr", 32'(frame_err), 32'd0);

    // Bad stop bit followed by a long break, then a clean byte.
    applyStimulus(8'h3C, 1'b0, BIT_NS);
    #(40 * BIT_NS);
    settle();
    checkOutput("breakFrameErr", 32'(frame_err), 32'd1);
    checkOutput("breakCount", 32'(fifo_count), 32'd0);
    rxd = 1'b1;
    #(2 * BIT_NS);
    applyStimulus(8'h55, 1'b1, BIT_NS);
    settle();
    checkOutput("after55Count", 32'(fifo_count), 32'd1);
    checkOutput("after55Data", 32'(rx_data), 32'h55);
    checkOutput("after55FrameErr", 32'(frame_err), 32'd1);
    popOne();
    clearErrors();
    checkOutput("clrFrameErr", 32'(frame_err), 32'd0);

    // Five bytes into a four-entry FIFO: the fifth is dropped.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(8'(i), 1'b1, BIT_NS);
    end
    settle();
    checkOutput("ovfCount", 32'(fifo_count), 32'd4);
    checkOutput("ovfFlag", 32'(overflow), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("ovfPopData", 32'(rx_data), 32'(i));
      popOne();
    end
    checkOutput("ovfDrainCount", 32'(fifo_count), 32'd0);
    clearErrors();
    checkOutput("clrOverflow", 32'(overflow), 32'd0);

    // Full FIFO; the fifth byte's push edge coincides with a pop. The pop edge
    // is 156 rising edges after the edge that launches the frame.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h10 + 8'(i), 1'b1, BIT_NS);
    end
    settle();
    checkOutput("fullCount", 32'(fifo_count), 32'd4);
    fork
      applyStimulus(8'h14, 1'b1, BIT_NS);
      begin
        @(posedge HCLK);
        repeat (155) @(posedge HCLK);
        #1 rx_ready = 1'b1;
        @(posedge HCLK);
        #1 rx_ready = 1'b0;
      end
    join
    settle();
    checkOutput("simulOverflow", 32'(overflow), 32'd0);
    checkOutput("simulCount", 32'(fifo_count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("simulPopData", 32'(rx_data), 32'h10 + 32'(i));
      popOne();
    end

    // Leave a byte and a frame error pending, then reset in the middle of a
    // frame for 8'hFF.
    applyStimulus(8'h77, 1'b1, BIT_NS);
    applyStimulus(8'h3C, 1'b0, BIT_NS);
    rxd = 1'b1;
    settle();
    checkOutput("preRstCount", 32'(fifo_count), 32'd1);
    checkOutput("preRstFrameErr", 32'(frame_err), 32'd1);
    @(posedge HCLK);
    #2;
    rxd = 1'b0;
    #(BIT_NS);
    rxd = 1'b1;
    #(4 * BIT_NS + BIT_NS / 2);
    hwRst = 1'b1;
    #30;
    hwRst = 1'b0;
    #(5 * BIT_NS);
    settle();
    checkOutput("midRstCount", 32'(fifo_count), 32'd0);
    checkOutput("midRstValid", 32'(rx_valid), 32'd0);
    checkOutput("midRstFrameErr", 32'(frame_err), 32'd0);
    checkOutput("midRstData", 32'(rx_data), 32'h00);
    applyStimulus(8'h81, 1'b1, BIT_NS);
    settle();
    checkOutput("after81Count", 32'(fifo_count), 32'd1);
    checkOutput("after81Data", 32'(rx_data), 32'h81);
    checkOutput("after81FrameErr", 32'(frame_err), 32'd0);
    checkOutput("after81Overflow", 32'(overflow), 32'd0);
    popOne();

    // Baud tolerance: roughly +3% and -3% bit period.
    applyStimulus(8'hC3, 1'b1, 165);
    settle();
    checkOutput("slowCount", 32'(fifo_count), 32'd1);
    checkOutput("slowData", 32'(rx_data), 32'hC3);
    popOne();
    applyStimulus(8'hC3, 1'b1, 155);
    settle();
    checkOutput("fastCount", 32'(fifo_count), 32'd1);
    checkOutput("fastData", 32'(rx_data), 32'hC3);
    checkOutput("fastFrameErr", 32'(frame_err), 32'd0);
    popOne();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
